// File: rtl/iic_reg_bank.sv
// iic_reg_bank: a byte-wide register bank that sits behind an I2C slave.
// The first byte of a master write sets the register pointer. Later bytes
// are written to the bank. Read requests load the addressed byte into
// Data_In for transmission. A host port gives local read/write access.
// Optional feature: define IIC_REG_AUTOINC_EN to make the pointer advance
// after every data write and every read request.
// Limitation: ADDR_W must not exceed 8, because the pointer is loaded from
// one received byte.
module iic_reg_bank #(
    parameter int ADDR_W    = 4,
    parameter int PTR_RESET = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [7:0]        Data_Out,
    input  logic              Byte_TC,
    input  logic              Read_Req,
    input  logic              P,
    output logic [7:0]        Data_In,
    input  logic [ADDR_W-1:0] Host_Addr,
    output logic [7:0]        Host_Rdata,
    input  logic              Host_We,
    input  logic [7:0]        Host_Wdata,
    output logic              Wr_Strobe,
    output logic [ADDR_W-1:0] Wr_Addr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_RST = PTR_RESET[ADDR_W-1:0];

`ifdef IIC_REG_AUTOINC_EN
    localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] PTR_STEP = '0;
`endif

    typedef enum logic {
        S_PTR  = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        din_q, din_d;
    logic              strobe_q, strobe_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              i2c_we;
    logic [7:0]        bank_q [DEPTH];

    // Control registers: FSM state, pointer, transmit byte and the write-report pair.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_PTR;
            ptr_q    <= PTR_RST;
            din_q    <= 8'h00;
            strobe_q <= 1'b0;
            waddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            din_q    <= din_d;
            strobe_q <= strobe_d;
            waddr_q  <= waddr_d;
        end
    end

    // Next state: STOP beats byte-complete, and byte-complete beats read request.
    // Lower-priority pulses in the same cycle are dropped.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        din_d    = din_q;
        strobe_d = 1'b0;
        waddr_d  = waddr_q;
        i2c_we   = 1'b0;
        if (P) begin
            // The pointer and Data_In survive STOP, so a read that starts with
            // a repeated START continues from the pointer that was just written.
            state_d = S_PTR;
        end else if (Byte_TC) begin
            if (state_q == S_PTR) begin
                ptr_d   = Data_Out[ADDR_W-1:0];
                state_d = S_DATA;
            end else begin
                i2c_we   = 1'b1;
                strobe_d = 1'b1;
                waddr_d  = ptr_q;
                ptr_d    = ptr_q + PTR_STEP;
            end
        end else if (Read_Req) begin
            // Register bank reads see the value before this cycle's host write.
            din_d   = bank_q[ptr_q];
            ptr_d   = ptr_q + PTR_STEP;
            state_d = S_DATA;
        end
    end

    // Bank storage: a host write is suppressed only when I2C writes the same byte.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else begin
            if (Host_We && !(i2c_we && (Host_Addr == ptr_q))) begin
                bank_q[Host_Addr] <= Host_Wdata;
            end
            if (i2c_we) begin
                bank_q[ptr_q] <= Data_Out;
            end
        end
    end

    assign Host_Rdata = bank_q[Host_Addr];
    assign Data_In    = din_q;
    assign Wr_Strobe  = strobe_q;
    assign Wr_Addr    = waddr_q;

endmodule

// File: tb/tb_iic_reg_bank.sv
// Testbench for iic_reg_bank: directed scenarios plus random pulse traffic.
// The reference model is a plain array, a pointer and a pointer-phase flag.
// Expected write reports and read bytes are queued and checked by a monitor.
module tb_iic_reg_bank;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
`ifdef IIC_REG_AUTOINC_EN
    localparam int STEP = 1;
`else
    localparam int STEP = 0;
`endif

    logic              CLK;
    logic              RSTn;
    logic [7:0]        Data_Out;
    logic              Byte_TC;
    logic              Read_Req;
    logic              P;
    logic [7:0]        Data_In;
    logic [ADDR_W-1:0] Host_Addr;
    logic [7:0]        Host_Rdata;
    logic              Host_We;
    logic [7:0]        Host_Wdata;
    logic              Wr_Strobe;
    logic [ADDR_W-1:0] Wr_Addr;

    iic_reg_bank #(.ADDR_W(ADDR_W), .PTR_RESET(0)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Data_Out   (Data_Out),
        .Byte_TC    (Byte_TC),
        .Read_Req   (Read_Req),
        .P          (P),
        .Data_In    (Data_In),
        .Host_Addr  (Host_Addr),
        .Host_Rdata (Host_Rdata),
        .Host_We    (Host_We),
        .Host_Wdata (Host_Wdata),
        .Wr_Strobe  (Wr_Strobe),
        .Wr_Addr    (Wr_Addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0] m_bank [DEPTH];
    int         m_ptr;
    bit         m_ptr_phase;

    // Scoreboard queues.
    int         wr_q [$];
    logic [7:0] rd_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic [7:0] exp_din = 8'h00;
    bit         rd_fire = 1'b0;
    always @(negedge CLK) begin
        if (!RSTn) begin
            exp_din = 8'h00;
            rd_fire = 1'b0;
            chk("rst_data_in", Data_In, 8'h00);
            chk("rst_wr_strobe", Wr_Strobe, 1'b0);
        end else begin
            if (rd_fire) begin
                if (rd_q.size() == 0) begin
                    chk("read_without_expectation", 1, 0);
                end else begin
                    exp_din = rd_q.pop_front();
                end
            end
            chk("data_in", Data_In, exp_din);
            if (Wr_Strobe) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_wr_strobe", 1, 0);
                end else begin
                    chk("wr_addr", Wr_Addr, wr_q.pop_front());
                end
            end
            rd_fire = Read_Req && !P && !Byte_TC;
        end
    end

    // Apply one clock of stimulus; the model is updated from the behavioural rules.
    task automatic step(input bit p, input bit tc, input bit rr, input logic [7:0] dout,
                        input bit we, input int ha, input logic [7:0] hd);
        bit i2c_w = 1'b0;
        int wa    = 0;
        if (p) begin
            m_ptr_phase = 1'b1;
        end else if (tc) begin
            if (m_ptr_phase) begin
                m_ptr       = dout % DEPTH;
                m_ptr_phase = 1'b0;
            end else begin
                i2c_w = 1'b1;
                wa    = m_ptr;
                wr_q.push_back(m_ptr);
                m_ptr = (m_ptr + STEP) % DEPTH;
            end
        end else if (rr) begin
            rd_q.push_back(m_bank[m_ptr]);
            m_ptr       = (m_ptr + STEP) % DEPTH;
            m_ptr_phase = 1'b0;
        end
        if (we) m_bank[ha] = hd;
        if (i2c_w) m_bank[wa] = dout;

        P          = p;
        Byte_TC    = tc;
        Read_Req   = rr;
        Data_Out   = dout;
        Host_We    = we;
        Host_Addr  = ADDR_W'(ha);
        Host_Wdata = hd;
        @(posedge CLK);
        #1;
        P        = 1'b0;
        Byte_TC  = 1'b0;
        Read_Req = 1'b0;
        Host_We  = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic tc(input logic [7:0] b);
        step(0, 1, 0, b, 0, 0, 8'h00);
    endtask

    task automatic stop();
        step(1, 0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic rd();
        step(0, 0, 1, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic hw(input int a, input logic [7:0] d);
        step(0, 0, 0, 8'h00, 1, a, d);
    endtask

    // Read the whole bank through the host port and confirm the scoreboard drained.
    task automatic check_bank(input string name);
        P = 0; Byte_TC = 0; Read_Req = 0; Host_We = 0;
        for (int i = 0; i < DEPTH; i++) begin
            Host_Addr = ADDR_W'(i);
            #1;
            chk(name, Host_Rdata, m_bank[i]);
        end
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        chk({name, "_wr_q_drained"}, wr_q.size(), 0);
        chk({name, "_rd_q_drained"}, rd_q.size(), 0);
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        P = 0; Byte_TC = 0; Read_Req = 0; Host_We = 0;
        Data_Out = 8'h00; Host_Addr = '0; Host_Wdata = 8'h00;
        wr_q.delete();
        rd_q.delete();
        for (int i = 0; i < DEPTH; i++) m_bank[i] = 8'h00;
        m_ptr       = 0;
        m_ptr_phase = 1'b1;
        @(posedge CLK);
        #3;
        chk("rst_wr_addr", Wr_Addr, 0);
        chk("rst_host_rdata", Host_Rdata, 8'h00);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    initial begin
        RSTn = 1'b0;
        P = 0; Byte_TC = 0; Read_Req = 0; Host_We = 0;
        Data_Out = 8'h00; Host_Addr = '0; Host_Wdata = 8'h00;
        #2;
        do_reset();
        check_bank("reset_bank");

        // Pointer then two data bytes.
        tc(8'h03); tc(8'h5A); tc(8'hA5); idle();
        check_bank("ptr_data_write");

        // Pointer at the top of the range; upper bits of the pointer byte ignored.
        stop(); tc(8'hFF); tc(8'h11); tc(8'h22); stop();
        check_bank("wrap");

        // Read after STOP with a repeated-start style sequence.
        hw(2, 8'h77); hw(3, 8'h88);
        tc(8'h02); stop(); rd(); idle(); rd(); idle();
        check_bank("read_after_stop");

        // Same-address collision: the I2C byte wins.
        stop(); tc(8'h04);
        step(0, 1, 0, 8'h10, 1, 4, 8'hFF);
        Host_Addr = 4'd4;
        #1;
        chk("collision_bank4", Host_Rdata, 8'h10);
        // Different-address host write alongside an I2C write.
        step(0, 1, 0, 8'h20, 1, 9, 8'h99);
        idle();
        check_bank("collision");

        // Simultaneous pulses: STOP dominates, then byte-complete over read.
        step(1, 1, 1, 8'h0C, 0, 0, 8'h00);
        step(0, 1, 1, 8'h0C, 0, 0, 8'h00);
        step(0, 1, 1, 8'h3C, 0, 0, 8'h00);
        rd(); idle();
        check_bank("priority");

        // Reset in the middle of a transfer discards the pointer.
        stop(); tc(8'h06);
        do_reset();
        tc(8'h09);
        idle();
        check_bank("reset_mid_op");
        tc(8'h33);
        Host_Addr = 4'd9;
        #1;
        chk("after_reset_ptr9", Host_Rdata, 8'h33);
        idle();
        check_bank("after_reset");

        // Pointer 1, then two data bytes.
        stop(); tc(8'h01); tc(8'hAA); tc(8'hBB); idle();
        check_bank("two_writes");

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 7) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0,
                     8'($urandom),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, DEPTH - 1),
                     8'($urandom));
            end
            if ((n % 60) == 59) check_bank("random");
        end
        check_bank("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
